player_bullet_controller: RTL
=============================

# player_bullet_controller

Owns the player's pool of bullets: spawns a bullet on a fire request, advances every active bullet upward on a fixed tick, and retires bullets that leave the top of the screen or are reported hit. Drives the flat bullet position/active buses consumed by the enemy controllers for collision, and accepts their per-slot hit feedback. Sits between the player input/position logic and all enemy controllers in the clk25 domain.

## Interface
- NUM_BULLETS, 8, pool size; bus widths scale with it
- MOVE_DIV, 250_000, clk25 cycles per movement tick
- SPEED, 4, pixels moved upward per tick
- COOLDOWN, 3_000_000, minimum clk25 cycles between successive spawns
- SPAWN_X_OFS, 12, added to player_x for spawn x
- SPAWN_Y_OFS, 8, subtracted from player_y for spawn y
- clk25  in  1  25 MHz pixel clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  game running; low clears the pool synchronously
- fire  in  1  raw fire button, asynchronous to clk25
- player_x  in  10  player sprite left edge
- player_y  in  10  player sprite top edge
- hit_flat  in  NUM_BULLETS  per-slot hit pulse from enemy controllers (OR of all enemies)
- bullet_x_flat  out  NUM_BULLETS*10  slot i at [i*10 +: 10]
- bullet_y_flat  out  NUM_BULLETS*10  slot i at [i*10 +: 10]
- bullet_active_flat  out  NUM_BULLETS  slot i live

## Operation
- Reset (rst_n low, async): all x/y = 0, all active = 0, tick prescaler = 0, cooldown = 0, synchronizer flops = 0.
- enable low (sync): same state as reset; fire ignored.
- Fire path: 2-flop synchronizer, then rising-edge detect → spawn request.
- Spawn: accepted when request, cooldown == 0, and at least one slot inactive in the current registered state. Target = lowest-index inactive slot. x = player_x + SPAWN_X_OFS (10-bit, wraps); y = player_y − SPAWN_Y_OFS, saturating at 0. Accept loads cooldown = COOLDOWN − 1; cooldown decrements to 0 each cycle.
- Pool full or cooldown nonzero: request dropped, not queued; cooldown not reloaded.
- Movement: prescaler counts 0..MOVE_DIV−1; on terminal count every active slot with y ≥ SPEED gets y −= SPEED; slot with y < SPEED is retired instead.
- Retire (top exit, hit, or enable low): active ← 0, x ← 0, y ← 0.
- Simultaneous events on one slot, priority: hit > move. A slot retired this cycle is not reusable until next cycle (spawn uses pre-cycle free mask). A slot spawned this cycle is not moved until the next tick.
- hit_flat bit on an inactive slot: ignored.

## Timing
- fire high first sampled at edge k → slot active on outputs after edge k+2.
- Hit pulse sampled at edge k → slot inactive after edge k.
- Movement: positions update on the edge where prescaler wraps; first tick MOVE_DIV edges after reset/enable rise.
- All outputs registered; no combinational input→output paths.

## Configuration
- BULLET_AUTOFIRE_EN defined: spawn request = synchronized fire level; holding fire spawns every COOLDOWN cycles while a slot is free.
- Undefined: spawn request = rising edge only; holding fire yields exactly one bullet per press.

## Structure
- Shared package/header: NUM_BULLETS, COORD_W = 10, SCREEN_W = 640, SCREEN_H = 480, BULLET_W = 8 (shared with enemy collision boxes).
- Sub-module fire_input_sync: 2-flop synchronizer + edge detector, rst_n-reset, exposes level and rise outputs.
- Slot array, free-slot priority encoder, prescaler, cooldown in the top module.

## Test plan
(Bench params: MOVE_DIV=4, COOLDOWN=10, SPEED=4.)
- Reset release, fire held low 50 cycles → all flat outputs 0.
- player_x=300, player_y=400, fire pulse → slot 0 active, x=312, y=392 after edge k+2; y=388 after next tick.
- Eight presses spaced 12 cycles → slots 0..7 active; ninth press → no change, cooldown stays 0.
- hit_flat[3] pulse with slot 3 active → slot 3 active=0, x=y=0 same edge; next press fills slot 3.
- Slot with y=6 → next tick y=2, following tick retired; player_y=4 spawn → y=0.
- Fire held 40 cycles: without BULLET_AUTOFIRE_EN one bullet; with it bullets at cycles k+2, +10, +20, +30 (four spawns).

Source files
------------

// File: rtl/player_bullet_controller_pkg.sv
// Shared constants for the player bullet pool and the enemy collision logic.
//   NUM_BULLETS : default pool size
//   COORD_W     : width of every screen coordinate
//   SCREEN_W/H  : visible area in pixels
//   BULLET_W    : bullet sprite edge, reused by enemy collision boxes
package player_bullet_controller_pkg;

    localparam int unsigned NUM_BULLETS = 8;
    localparam int unsigned COORD_W     = 10;
    localparam int unsigned SCREEN_W    = 640;
    localparam int unsigned SCREEN_H    = 480;
    localparam int unsigned BULLET_W    = 8;

    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/player_bullet_controller_if.sv
// Bullet bus between the player logic, the bullet controller and the enemy controllers.
//   master : game/player side; drives enable, fire, player position and hit feedback
//   slave  : bullet controller; drives the flat bullet x/y/active buses
interface player_bullet_controller_if #(
    parameter int unsigned NUM_BULLETS = player_bullet_controller_pkg::NUM_BULLETS
) ();
    import player_bullet_controller_pkg::*;

    logic                           enable;
    logic                           fire;
    logic [COORD_W-1:0]             player_x;
    logic [COORD_W-1:0]             player_y;
    logic [NUM_BULLETS-1:0]         hit_flat;
    logic [NUM_BULLETS*COORD_W-1:0] bullet_x_flat;
    logic [NUM_BULLETS*COORD_W-1:0] bullet_y_flat;
    logic [NUM_BULLETS-1:0]         bullet_active_flat;

    modport master (
        output enable, fire, player_x, player_y, hit_flat,
        input  bullet_x_flat, bullet_y_flat, bullet_active_flat
    );

    modport slave (
        input  enable, fire, player_x, player_y, hit_flat,
        output bullet_x_flat, bullet_y_flat, bullet_active_flat
    );

endinterface

// File: rtl/fire_input_sync.sv
// Brings the raw fire button into clk25 and detects presses.
//   clk25, rst_n : clock and async active-low reset
//   clr          : synchronous clear of all flops (game disabled)
//   fire_async   : raw button, asynchronous to clk25
//   level        : synchronized button level
//   rise         : one-cycle pulse on a synchronized rising edge
module fire_input_sync (
    input  logic clk25,
    input  logic rst_n,
    input  logic clr,
    input  logic fire_async,
    output logic level,
    output logic rise
);
    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else if (clr) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], fire_async};
            prev_q <= sync_q[1];
        end
    end

    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~prev_q;

endmodule

// File: rtl/player_bullet_controller.sv
// Player bullet pool: spawns on fire, moves bullets up each tick, retires on top exit or hit.
//   clk25, rst_n : 25 MHz clock, async active-low reset
//   bus (slave)  : enable, fire, player_x/y, hit_flat in; bullet x/y/active flat buses out
// Build option: BULLET_AUTOFIRE_EN makes the held fire level the spawn request
// (repeat fire at the cooldown rate); otherwise one bullet per press.
module player_bullet_controller #(
    parameter int unsigned NUM_BULLETS = player_bullet_controller_pkg::NUM_BULLETS,
    parameter int unsigned MOVE_DIV    = 250_000,
    parameter int unsigned SPEED       = 4,
    parameter int unsigned COOLDOWN    = 3_000_000,
    parameter int unsigned SPAWN_X_OFS = 12,
    parameter int unsigned SPAWN_Y_OFS = 8
) (
    input  logic                         clk25,
    input  logic                         rst_n,
    player_bullet_controller_if.slave    bus
);
    import player_bullet_controller_pkg::*;

    localparam int unsigned PRESC_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int unsigned CD_W    = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam int unsigned IDX_W   = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;

    coord_t                 x_q [NUM_BULLETS];
    coord_t                 y_q [NUM_BULLETS];
    coord_t                 x_d [NUM_BULLETS];
    coord_t                 y_d [NUM_BULLETS];
    logic [NUM_BULLETS-1:0] active_q, active_d;
    logic [PRESC_W-1:0]     presc_q, presc_d;
    logic [CD_W-1:0]        cd_q, cd_d;

    logic       fire_level, fire_rise, spawn_req;
    logic       free_found, tick, spawn;
    logic [IDX_W-1:0] free_idx;
    coord_t     spawn_x, spawn_y;

    fire_input_sync u_fire_sync (
        .clk25      (clk25),
        .rst_n      (rst_n),
        .clr        (!bus.enable),
        .fire_async (bus.fire),
        .level      (fire_level),
        .rise       (fire_rise)
    );

`ifdef BULLET_AUTOFIRE_EN
    assign spawn_req = fire_level;
    logic unused_fire_rise;
    assign unused_fire_rise = fire_rise;
`else
    assign spawn_req = fire_rise;
    logic unused_fire_level;
    assign unused_fire_level = fire_level;
`endif

    // Lowest-index free slot, from the registered (pre-cycle) active mask.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            if (!active_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign tick    = (presc_q == PRESC_W'(MOVE_DIV - 1));
    assign spawn   = spawn_req && (cd_q == '0) && free_found;
    assign spawn_x = bus.player_x + COORD_W'(SPAWN_X_OFS);
    assign spawn_y = (bus.player_y >= COORD_W'(SPAWN_Y_OFS)) ?
                     bus.player_y - COORD_W'(SPAWN_Y_OFS) : '0;

    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        active_d = active_q;
        presc_d  = tick ? '0 : presc_q + 1'b1;
        cd_d     = (cd_q != '0) ? cd_q - 1'b1 : cd_q;
        if (spawn) cd_d = CD_W'(COOLDOWN - 1);

        for (int i = 0; i < NUM_BULLETS; i++) begin
            // Spawn only targets a free slot, so it never collides with hit/move.
            if (spawn && (free_idx == IDX_W'(i))) begin
                active_d[i] = 1'b1;
                x_d[i]      = spawn_x;
                y_d[i]      = spawn_y;
            end else if (active_q[i] && bus.hit_flat[i]) begin
                active_d[i] = 1'b0;
                x_d[i]      = '0;
                y_d[i]      = '0;
            end else if (active_q[i] && tick) begin
                if (y_q[i] >= COORD_W'(SPEED)) begin
                    y_d[i] = y_q[i] - COORD_W'(SPEED);
                end else begin
                    active_d[i] = 1'b0;
                    x_d[i]      = '0;
                    y_d[i]      = '0;
                end
            end
        end

        if (!bus.enable) begin
            active_d = '0;
            presc_d  = '0;
            cd_d     = '0;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                x_d[i] = '0;
                y_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= '0;
            presc_q  <= '0;
            cd_q     <= '0;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            active_q <= active_d;
            presc_q  <= presc_d;
            cd_q     <= cd_d;
            x_q      <= x_d;
            y_q      <= y_d;
        end
    end

    for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_flat
        assign bus.bullet_x_flat[g*COORD_W +: COORD_W] = x_q[g];
        assign bus.bullet_y_flat[g*COORD_W +: COORD_W] = y_q[g];
    end
    assign bus.bullet_active_flat = active_q;

endmodule
